dmem_bus_ctrl: RTL and testbench
================================

Name: dmem_bus_ctrl

Overview:
- Sits directly downstream of the load/store formatting stage.
- Takes its word-aligned address, read/write command, lane-positioned write data and byte mask, and runs one transaction on a valid/ready data-memory bus.
- Stalls the pipeline until the transaction completes, then returns the raw 32-bit load word (load_data) to the formatting stage for shifting and sign-extension.
- A timeout watchdog terminates transactions the bus never completes.

Parameters:
- TIMEOUT_CYCLES, 255: maximum number of cycles spent in REQ plus WAIT_RESP before the transaction is aborted. Range 1..65535.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  current instruction is a load or store
- cmd  in  1  1 = store, 0 = load
- addr  in  32  word-aligned address; bits [1:0] are always 0
- wdata  in  32  lane-shifted store data
- wmask  in  4  byte-lane write enables
- stall  out  1  holds the pipeline
- load_data  out  32  registered raw load word
- err  out  1  one-cycle pulse on timeout abort
- bus_valid  out  1  request valid
- bus_ready  in  1  request accepted when bus_valid and bus_ready are both high
- bus_we  out  1  write enable
- bus_addr  out  32  request address
- bus_wdata  out  32  write data
- bus_wstrb  out  4  byte strobes
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read data

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE; bus_valid, bus_we, err = 0; bus_addr, bus_wdata, load_data = 0; bus_wstrb = 0; timeout counter = 0. Asserting rst mid-transaction drops bus_valid immediately and abandons the transaction. A bus_rvalid arriving after reset release is ignored.
- FSM states: IDLE, REQ, WAIT_RESP, DONE.
- IDLE:
  - stall = req_valid, combinational, so the pipeline freezes in the same cycle.
  - If req_valid, latch the bus_* outputs from cmd/addr/wdata/wmask.
  - A store with wmask == 0 goes directly to DONE and never touches the bus.
  - Otherwise go to REQ with bus_valid = 1.
- REQ:
  - stall = 1. bus_* outputs are stable while bus_valid is high.
  - On bus_ready: bus_valid <= 0. A store goes to DONE; a load goes to WAIT_RESP.
  - bus_rvalid is ignored in REQ; the bus guarantees read data at least 1 cycle after acceptance.
- WAIT_RESP:
  - stall = 1.
  - On bus_rvalid: load_data <= bus_rdata, go to DONE.
- DONE:
  - stall = 0 for exactly one cycle, so the pipeline advances. Always return to IDLE.
  - req_valid seen in DONE belongs to the finishing instruction and must not start a new transaction.
- Timeout:
  - The counter is cleared on IDLE exit and increments each cycle in REQ or WAIT_RESP.
  - When it reaches TIMEOUT_CYCLES: bus_valid <= 0, go to DONE, err pulses high for the DONE cycle.
  - An aborted load sets load_data <= 32'h0. An aborted store has no further effect.
  - If the terminating bus event and the timeout occur in the same cycle, the bus event wins and err stays 0.
- Latency:
  - Store with bus_ready high: 3 cycles total (IDLE, REQ, DONE). Stall is high for 2 cycles.
  - Load with ready at first offer and rvalid 1 cycle later: 4 cycles total.
- load_data holds its value between loads. Stores never modify load_data.
- Back-to-back requests: a new req_valid may be taken in the IDLE cycle immediately after DONE, with no bubble beyond DONE.

Decomposition:
- defines.vh gets:
  - the FSM state encodings: IDLE 2'd0, REQ 2'd1, WAIT_RESP 2'd2, DONE 2'd3;
  - the CMD_LOAD / CMD_STORE constants;
  - the timeout error load value (32'h0).
- One sub-module is natural: bus_timeout_counter, a clearable saturating counter with a terminal-count flag, parameterised by TIMEOUT_CYCLES, on the same clk/rst.

Test Plan:
1. Store: addr 0x100, wdata 0x0000AB00, wmask 4'b0010, bus_ready held high -> one bus cycle with bus_we = 1, addr 0x100, wstrb 0010; stall high for exactly 2 cycles; load_data unchanged; err = 0.
2. Load: addr 0x200, ready after 3 wait cycles, rvalid with 0xDEADBEEF 2 cycles later -> bus_* stable through the waits; load_data = 0xDEADBEEF from the DONE cycle onward; stall deasserts only in DONE.
3. Back-to-back load then store, each held until stall falls -> exactly 2 bus transactions, no duplicate request caused by DONE-cycle req_valid; total 7 cycles with a zero-wait bus.
4. TIMEOUT_CYCLES = 4, load, bus_ready never asserted -> bus_valid drops after 4 REQ cycles; err = 1 for one cycle; load_data = 0; FSM returns to IDLE. Repeat with ready arriving on cycle 4 -> transaction completes normally with err = 0.
5. Store with wmask = 0 -> bus_valid never asserts; stall high for 1 cycle; DONE follows.
6. rst pulsed while in WAIT_RESP, then a late bus_rvalid with 0x12345678 -> bus_valid = 0 and stall = 0 asynchronously; load_data stays 0; the late rvalid is ignored.

Source files
------------

// File: rtl/dmem_bus_ctrl_pkg.sv
// Shared types and constants for the data-memory bus controller.
package dmem_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StReq      = 2'd1,
        StWaitResp = 2'd2,
        StDone     = 2'd3
    } state_e;

    localparam logic CMD_LOAD  = 1'b0;
    localparam logic CMD_STORE = 1'b1;

    // Value returned to the formatting stage when a load is aborted.
    localparam logic [31:0] TIMEOUT_LOAD_DATA = 32'h0;

endpackage

// File: rtl/dmem_bus_ctrl_timeout.sv
// Clearable saturating cycle counter; tc flags the last allowed cycle of a transaction.
module dmem_bus_ctrl_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] MAX  = W'(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && cnt_q != MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter holds cycles already spent, so the current cycle is the last one at LAST.
    assign tc = en && (cnt_q >= LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Runs one load/store transaction on a valid/ready data bus, stalling the pipeline until done.
module dmem_bus_ctrl
    import dmem_bus_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        cmd,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        err,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    state_e      state_q, state_d;
    logic        bus_valid_q, bus_valid_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;
    logic [31:0] load_data_q, load_data_d;
    logic        err_q, err_d;
    logic        tmo_tc;
    logic        abort;

    dmem_bus_ctrl_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (state_q == StIdle),
        .en  ((state_q == StReq) || (state_q == StWaitResp)),
        .tc  (tmo_tc)
    );

    always_comb begin
        state_d     = state_q;
        bus_valid_d = bus_valid_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        load_data_d = load_data_q;
        err_d       = 1'b0;
        abort       = 1'b0;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    bus_we_d    = (cmd == CMD_STORE);
                    bus_addr_d  = addr;
                    bus_wdata_d = wdata;
                    bus_wstrb_d = wmask;
                    // An all-lanes-disabled store has nothing to write.
                    if (cmd == CMD_STORE && wmask == 4'b0000) begin
                        state_d = StDone;
                    end else begin
                        state_d     = StReq;
                        bus_valid_d = 1'b1;
                    end
                end
            end
            StReq: begin
                if (bus_ready) begin
                    bus_valid_d = 1'b0;
                    state_d     = bus_we_q ? StDone : StWaitResp;
                end else if (tmo_tc) begin
                    abort = 1'b1;
                end
            end
            StWaitResp: begin
                if (bus_rvalid) begin
                    load_data_d = bus_rdata;
                    state_d     = StDone;
                end else if (tmo_tc) begin
                    abort = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort) begin
            bus_valid_d = 1'b0;
            state_d     = StDone;
            err_d       = 1'b1;
            if (!bus_we_q) begin
                load_data_d = TIMEOUT_LOAD_DATA;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
            load_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_valid_q <= bus_valid_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
            load_data_q <= load_data_d;
            err_q       <= err_d;
        end
    end

    // Freeze the pipeline in the same cycle a request is presented.
    assign stall = (state_q == StIdle) ? req_valid : (state_q != StDone);

    assign bus_valid = bus_valid_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wstrb = bus_wstrb_q;
    assign load_data = load_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Randomized self-checking bench for dmem_bus_ctrl against a transaction-level reference model.
module tb_dmem_bus_ctrl;

    // Small enough that random bus delays regularly hit the watchdog, large enough that a
    // 3-wait-ready load with rvalid 2 cycles later lands exactly on the limit.
    localparam int unsigned T = 6;

    logic        clk, rst;
    logic        req_valid, cmd;
    logic [31:0] addr, wdata;
    logic [3:0]  wmask;
    logic        stall, err;
    logic [31:0] load_data;
    logic        bus_valid, bus_ready, bus_we, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_ld   = 32'h0;

    dmem_bus_ctrl #(
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .cmd        (cmd),
        .addr       (addr),
        .wdata      (wdata),
        .wmask      (wmask),
        .stall      (stall),
        .load_data  (load_data),
        .err        (err),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wstrb  (bus_wstrb),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one request held until stall falls; the bus answers ready after r refused
    // cycles and (for loads) rvalid on the d-th cycle after acceptance.
    task automatic run_txn(input logic is_st, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] wm, input int r, input int d,
                           input logic [31:0] rd, output int ncyc);
        int  act, lim, exp_stall, exp_valid, exp_acc;
        bit  skip, exp_err, done, acc_seen;
        int  stall_cyc, valid_cyc, accepts, unstable, err_early, req_seen, wait_cnt;

        // Reference model: count of cycles spent in the bus phase and whether it aborted.
        skip    = is_st && (wm == 4'b0000);
        exp_err = 1'b0;
        if (skip) begin
            act = 0;
        end else if (r + 1 > int'(T)) begin
            act = T; exp_err = 1'b1;
        end else if (is_st) begin
            act = r + 1;
        end else begin
            lim = (int'(T) > r + 2) ? int'(T) : r + 2;
            if (r + 1 + d <= lim) act = r + 1 + d;
            else begin act = lim; exp_err = 1'b1; end
        end
        exp_stall = 1 + act;
        exp_valid = skip ? 0 : ((r + 1 > int'(T)) ? int'(T) : r + 1);
        exp_acc   = (skip || r + 1 > int'(T)) ? 0 : 1;
        if (!is_st) exp_ld = exp_err ? 32'h0 : rd;

        done = 0; acc_seen = 0;
        stall_cyc = 0; valid_cyc = 0; accepts = 0; unstable = 0; err_early = 0;
        req_seen = 0; wait_cnt = 0; ncyc = 0;

        @(negedge clk);
        req_valid = 1'b1; cmd = is_st; addr = a; wdata = wd; wmask = wm;
        bus_ready = 1'b0; bus_rvalid = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            ncyc++;
            if (stall) begin
                stall_cyc++;
                if (err) err_early++;
            end else begin
                done = 1;
                check_eq("err", {31'b0, err}, {31'b0, exp_err});
                check_eq("load_data", load_data, exp_ld);
                check_eq("stall_cycles", stall_cyc, exp_stall);
                check_eq("valid_cycles", valid_cyc, exp_valid);
                check_eq("accepts", accepts, exp_acc);
                check_eq("bus_unstable", unstable, 0);
                check_eq("err_early", err_early, 0);
                bus_ready = 1'b0; bus_rvalid = 1'b0;
            end
            if (!done) begin
                bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
                if (bus_valid) begin
                    valid_cyc++;
                    if (bus_addr !== a || bus_we !== is_st || bus_wdata !== wd ||
                        bus_wstrb !== wm) unstable++;
                    bus_ready = (req_seen == r);
                    if (bus_ready) begin
                        accepts++; acc_seen = 1; wait_cnt = 0;
                    end
                    req_seen++;
                    bus_rvalid = 1'($urandom_range(0, 1));
                end else if (acc_seen && !is_st) begin
                    wait_cnt++;
                    if (wait_cnt == d) begin
                        bus_rvalid = 1'b1; bus_rdata = rd;
                    end
                end
                @(negedge clk);
            end
        end
        check_eq("done_seen", {31'b0, done}, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_valid = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
            #1;
            check_eq("idle_stall", {31'b0, stall}, 32'd0);
            check_eq("idle_bus_valid", {31'b0, bus_valid}, 32'd0);
            check_eq("idle_err", {31'b0, err}, 32'd0);
        end
    endtask

    initial begin
        int c1, c2, nc;
        logic        st;
        logic [3:0]  wm;
        rst = 1'b1; req_valid = 1'b0; cmd = 1'b0; addr = '0; wdata = '0; wmask = '0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;

        #12;
        check_eq("rst_bus_valid", {31'b0, bus_valid}, 32'd0);
        check_eq("rst_bus_we", {31'b0, bus_we}, 32'd0);
        check_eq("rst_err", {31'b0, err}, 32'd0);
        check_eq("rst_stall", {31'b0, stall}, 32'd0);
        check_eq("rst_bus_addr", bus_addr, 32'h0);
        check_eq("rst_bus_wdata", bus_wdata, 32'h0);
        check_eq("rst_bus_wstrb", {28'b0, bus_wstrb}, 32'd0);
        check_eq("rst_load_data", load_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Reset while waiting for read data, then a stale rvalid.
        @(negedge clk);
        req_valid = 1'b1; cmd = 1'b0; addr = 32'h300; wmask = 4'hF;
        @(negedge clk);
        #1;
        check_eq("rr_req_valid", {31'b0, bus_valid}, 32'd1);
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        #1;
        check_eq("rr_wait_stall", {31'b0, stall}, 32'd1);
        rst = 1'b1; req_valid = 1'b0;
        #1;
        check_eq("rr_bus_valid", {31'b0, bus_valid}, 32'd0);
        check_eq("rr_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
        @(negedge clk);
        bus_rvalid = 1'b0;
        #1;
        check_eq("rr_load_data", load_data, 32'h0);
        check_eq("rr_err", {31'b0, err}, 32'd0);
        idle_cycles(2);

        // Directed cases.
        run_txn(1'b1, 32'h100, 32'h0000AB00, 4'b0010, 0, 1, 32'h0, nc);
        idle_cycles(1);
        run_txn(1'b0, 32'h200, 32'h0, 4'hF, 3, 2, 32'hDEADBEEF, nc);
        idle_cycles(1);
        run_txn(1'b0, 32'h204, 32'h0, 4'hF, 0, 1, 32'hCAFEF00D, c1);
        run_txn(1'b1, 32'h208, 32'h11223344, 4'hF, 0, 1, 32'h0, c2);
        check_eq("b2b_cycles", c1 + c2, 7);
        idle_cycles(1);
        run_txn(1'b0, 32'h20C, 32'h0, 4'hF, 100, 1, 32'h55AA55AA, nc);
        idle_cycles(1);
        run_txn(1'b1, 32'h210, 32'hA5A5A5A5, 4'b1001, T - 1, 1, 32'h0, nc);
        run_txn(1'b0, 32'h214, 32'h0, 4'hF, T - 1, 1, 32'h0BADF00D, nc);
        run_txn(1'b1, 32'h218, 32'hFFFFFFFF, 4'b0000, 0, 1, 32'h0, nc);
        idle_cycles(1);

        // Random traffic, including occasional zero-mask stores and watchdog aborts.
        for (int i = 0; i < 60; i++) begin
            st = 1'($urandom_range(0, 1));
            wm = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            run_txn(st, $urandom & 32'hFFFF_FFFC, $urandom, wm,
                    $urandom_range(0, T + 1), $urandom_range(1, 4), $urandom, nc);
            idle_cycles($urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
